alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, buffered execution unit for the out-of-order core. It sits between the ALU reservation station and the CDB arbiter. It accepts issued instructions into a DEPTH-entry FIFO and evaluates the RV32I integer and branch ops in one cycle. RV32M multiplies run on an iterative multiplier, MUL_STEP bits per cycle. Each result is held in an output register until the CDB grants it.

## Interface
- XLEN, 32: datapath width; power of 2.
- ROBBW, `ROBBW: ROB index width.
- DEPTH, 4: input FIFO entries; power of 2, at least 2.
- MUL_STEP, 4: multiplier bits consumed per cycle; must divide XLEN. NSTEP = XLEN/MUL_STEP.
- clk_in  input  1  clock; everything is on the rising edge.
- rst_in  input  1  reset, asynchronous and active-low.
- rdy_in  input  1  global enable; when low, all state is frozen.
- flush_in  input  1  mispredict clear, synchronous.
- in_valid  input  1  RS offers an instruction.
- in_ready  output  1  FIFO not full.
- in_code  input  6  opcode: the `Def.v` ALU, branch and jump codes, plus new `MUL, `MULH, `MULHSU and `MULHU.
- in_v1, in_v2, in_a, in_pc  input  XLEN each  operand 1, operand 2, immediate, instruction PC.
- in_rob_id  input  ROBBW  destination ROB entry.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  CDB grant.
- out_rob_id  output  ROBBW  ROB entry of the held result.
- out_val  output  XLEN  writeback value.
- out_rel_pc  output  XLEN  resolved next PC.

## Operation
**FIFO**
- Push: in_valid & in_ready & rdy_in & !flush_in.
- in_ready = (count != DEPTH). A pop in the same cycle does not free a slot early.
- Push and pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.

**Result fields, simple ops**
- out_val is per the RV32I semantics of the code. Shift amounts use operand[4:0]. SLT/SLTU results are zero-extended.
- out_rel_pc is pc+4 for every op except the following:
  - Branches: pc+A if taken, else pc+4; out_val = 0.
  - JAL: out_val = pc+4, out_rel_pc = pc+A.
  - JALR: out_val = pc+4, out_rel_pc = (v1+A) & ~1.
- Unknown codes: out_val = 0, out_rel_pc = pc+4.
- No field is ever left unassigned; the datapath has no latches.

**Multiply**
- MUL gives the low XLEN bits of the product. MULH, MULHSU and MULHU give the high XLEN bits, with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- Algorithm:
  - Latch the magnitudes and the result sign.
  - Do an unsigned shift-add of MUL_STEP multiplier bits per cycle into a 2·XLEN accumulator.
  - Conditionally negate on the final step.
- out_rel_pc = pc+4.

**FSM, states IDLE / MUL / HOLD**
- IDLE: result register is empty.
  - FIFO empty: stay in IDLE.
  - Head is a simple op: pop it and load the result; go to HOLD.
  - Head is a multiply: pop it, latch the operands, set cnt=0; go to MUL.
- MUL: one step per cycle, then cnt++.
  - At cnt == NSTEP-1, write the final result; go to HOLD.
- HOLD: out_valid = 1.
  - If out_ready, the result is consumed. In that same cycle, act as IDLE does on the FIFO head, which gives back-to-back issue.
  - Otherwise hold all out_* stable.

**Priority and freeze**
- Priority: reset > flush_in > rdy_in low > normal.
- flush_in:
  - Empties the FIFO and aborts a multiply in progress.
  - Drops the held result; that entry is not delivered even if out_ready is high.
  - Sets state to IDLE. A push offered in the same cycle is discarded.
- rdy_in low: no push, no pop, no FSM step, no consume; outputs hold.

**Reset (rst_in low)**
- FIFO empty, state IDLE.
- out_valid=0, out_val=0, out_rel_pc=0, out_rob_id=0, in_ready=1.
- Reset is asserted immediately, even mid-multiply, and released synchronously to clk_in.

## Timing
- Simple op, empty unit:
  - Pushed at edge k, popped and evaluated at edge k+1.
  - out_valid is high after edge k+1.
  - Input-to-CDB latency is 2 cycles.
- Multiply:
  - Popped at edge k+1; steps at edges k+2 … k+1+NSTEP.
  - out_valid is high after edge k+1+NSTEP, i.e. after k+9 for the defaults.
- Throughput:
  - Simple ops: one per cycle while out_ready stays high.
  - Multiplies: one per NSTEP+1 cycles.
- out_* change only at a consume, a flush or a reset.

## Test plan
- Reset, then ADD v1=5 v2=7 pushed at edge 0 → out_valid after edge 1, out_val=12, out_rel_pc=pc+4. SRA v1=0x80000000 v2=0x24 → out_val=0xF8000000.
- Four ADDIs pushed back-to-back with out_ready held low:
  - in_ready drops after the 4th push (DEPTH=4), and a 5th offer is not accepted.
  - Raising out_ready then delivers all four on consecutive cycles, in order, with correct rob_ids.
- BLT v1=-1 v2=0 A=0x10 pc=0x100 → out_rel_pc=0x110, out_val=0. JALR v1=0x203 A=0 pc=0x40 → out_val=0x44, out_rel_pc=0x202.
- Multiplies:
  - MULH 0xFFFFFFFF × 0xFFFFFFFF → 0; MULHU of the same operands → 0xFFFFFFFE.
  - MULHSU -2 × 3 → 0xFFFFFFFF; MUL 0x10000 × 0x10000 → 0.
  - out_valid goes high exactly 9 edges after the push edge.
- flush_in at step 3 of a MUL, with 2 entries queued → out_valid=0 and in_ready=1 next cycle. No entry is ever delivered, and a subsequent ADD completes normally.
- rdy_in low for 5 cycles mid-MUL with out_ready high → the step counter freezes and completion shifts by exactly 5 cycles. Asserting rst_in mid-MUL clears all outputs immediately.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: buffered integer execution unit between the ALU reservation
// station and the CDB arbiter. Instructions enter a DEPTH-entry FIFO. The
// FIFO head is evaluated in one cycle for RV32I ALU/branch/jump codes, or
// handed to an iterative shift-add multiplier (MUL_STEP bits per cycle) for
// the RV32M multiply codes. Each result waits in an output register until
// the CDB grants it.
//
// Ports:
//   clk_in      clock, rising edge
//   rst_in      asynchronous active-low reset
//   rdy_in      global enable; low freezes all state
//   flush_in    synchronous mispredict clear
//   in_valid    reservation station offers an instruction
//   in_ready    FIFO has a free slot
//   in_code     6-bit operation code (OP_* below)
//   in_v1/in_v2 register operands
//   in_a        immediate
//   in_pc       instruction PC
//   in_rob_id   destination ROB entry
//   out_valid   result register holds a result
//   out_ready   CDB grant
//   out_rob_id  ROB entry of the held result
//   out_val     writeback value
//   out_rel_pc  resolved next PC
module alu_pipe #(
    parameter int XLEN     = 32,
    parameter int ROBBW    = 4,
    parameter int DEPTH    = 4,
    parameter int MUL_STEP = 4
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_code,
    input  logic [XLEN-1:0]  in_v1,
    input  logic [XLEN-1:0]  in_v2,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [ROBBW-1:0] in_rob_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROBBW-1:0] out_rob_id,
    output logic [XLEN-1:0]  out_val,
    output logic [XLEN-1:0]  out_rel_pc
);

    localparam logic [5:0] OP_LUI    = 6'd1,  OP_AUIPC  = 6'd2,  OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR   = 6'd4,  OP_BEQ    = 6'd5,  OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT    = 6'd7,  OP_BGE    = 6'd8,  OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU   = 6'd10, OP_ADDI   = 6'd11, OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU  = 6'd13, OP_XORI   = 6'd14, OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI   = 6'd16, OP_SLLI   = 6'd17, OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI   = 6'd19, OP_ADD    = 6'd20, OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL    = 6'd22, OP_SLT    = 6'd23, OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR    = 6'd25, OP_SRL    = 6'd26, OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR     = 6'd28, OP_AND    = 6'd29, OP_MUL   = 6'd30;
    localparam logic [5:0] OP_MULH   = 6'd31, OP_MULHSU = 6'd32, OP_MULHU = 6'd33;

    localparam int NSTEP = XLEN / MUL_STEP;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam int SHW   = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST = CW'(NSTEP - 1);
    localparam logic [XLEN-1:0] FOUR = XLEN'(4);
    localparam logic [XLEN-1:0] ONE  = XLEN'(1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t state_q, state_d;

    logic [5:0]       codeMem [DEPTH];
    logic [XLEN-1:0]  v1Mem   [DEPTH];
    logic [XLEN-1:0]  v2Mem   [DEPTH];
    logic [XLEN-1:0]  aMem    [DEPTH];
    logic [XLEN-1:0]  pcMem   [DEPTH];
    logic [ROBBW-1:0] robMem  [DEPTH];

    logic [PW-1:0] headPtr_q, tailPtr_q;
    logic [PW:0]   count_q;

    logic [5:0]       headCode;
    logic [XLEN-1:0]  headV1, headV2, headA, headPc;
    logic [ROBBW-1:0] headRob;
    logic             headIsMul, push, pop;
    logic             loadSimple, startMul, mulStep, mulDone;

    logic [XLEN-1:0] simpleVal, simpleRelPc;
    logic            brTaken;

    logic [2*XLEN-1:0] mulMcand_q, mulAcc_q, mulPartial, mulAccNext, mulProduct;
    logic [XLEN-1:0]   mulMplier_q, mulPc4_q, mulResult;
    logic [ROBBW-1:0]  mulRob_q;
    logic [CW-1:0]     mulCnt_q;
    logic              mulNeg_q, mulHi_q;
    logic              aNeg, bNeg;
    logic [XLEN-1:0]   magA, magB;

    assign headCode = codeMem[headPtr_q];
    assign headV1   = v1Mem[headPtr_q];
    assign headV2   = v2Mem[headPtr_q];
    assign headA    = aMem[headPtr_q];
    assign headPc   = pcMem[headPtr_q];
    assign headRob  = robMem[headPtr_q];

    assign headIsMul = (headCode == OP_MUL) || (headCode == OP_MULH) ||
                       (headCode == OP_MULHSU) || (headCode == OP_MULHU);

    // A slot freed by a same-cycle pop is not offered until the next cycle.
    assign in_ready  = (count_q != (PW+1)'(DEPTH));
    assign push      = in_valid && in_ready && rdy_in && !flush_in;
    assign out_valid = (state_q == S_HOLD);

    // Only the high-half signed variants need magnitudes; MUL's low half is
    // identical for signed and unsigned operands.
    assign aNeg = ((headCode == OP_MULH) || (headCode == OP_MULHSU)) && headV1[XLEN-1];
    assign bNeg = (headCode == OP_MULH) && headV2[XLEN-1];
    assign magA = aNeg ? -headV1 : headV1;
    assign magB = bNeg ? -headV2 : headV2;

    // FSM next state. A consumed HOLD behaves like IDLE on the FIFO head so
    // results can issue back-to-back.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        loadSimple = 1'b0;
        startMul   = 1'b0;
        mulStep    = 1'b0;
        mulDone    = 1'b0;
        if (rdy_in && !flush_in) begin
            case (state_q)
                S_MUL: begin
                    mulStep = 1'b1;
                    if (mulCnt_q == LAST) begin
                        mulDone = 1'b1;
                        state_d = S_HOLD;
                    end
                end
                S_IDLE, S_HOLD: begin
                    if (state_q == S_IDLE || out_ready) begin
                        state_d = S_IDLE;
                        if (count_q != '0) begin
                            pop = 1'b1;
                            if (headIsMul) begin
                                startMul = 1'b1;
                                state_d  = S_MUL;
                            end else begin
                                loadSimple = 1'b1;
                                state_d    = S_HOLD;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Single-cycle evaluation of the FIFO head for the non-multiply codes.
    always_comb begin
        simpleVal   = '0;
        simpleRelPc = headPc + FOUR;
        brTaken     = 1'b0;
        case (headCode)
            OP_LUI:   simpleVal = headA;
            OP_AUIPC: simpleVal = headPc + headA;
            OP_JAL: begin
                simpleVal   = headPc + FOUR;
                simpleRelPc = headPc + headA;
            end
            OP_JALR: begin
                simpleVal   = headPc + FOUR;
                simpleRelPc = (headV1 + headA) & ~ONE;
            end
            OP_BEQ:   brTaken = (headV1 == headV2);
            OP_BNE:   brTaken = (headV1 != headV2);
            OP_BLT:   brTaken = ($signed(headV1) < $signed(headV2));
            OP_BGE:   brTaken = ($signed(headV1) >= $signed(headV2));
            OP_BLTU:  brTaken = (headV1 < headV2);
            OP_BGEU:  brTaken = (headV1 >= headV2);
            OP_ADDI:  simpleVal = headV1 + headA;
            OP_SLTI:  simpleVal = {{(XLEN-1){1'b0}}, $signed(headV1) < $signed(headA)};
            OP_SLTIU: simpleVal = {{(XLEN-1){1'b0}}, headV1 < headA};
            OP_XORI:  simpleVal = headV1 ^ headA;
            OP_ORI:   simpleVal = headV1 | headA;
            OP_ANDI:  simpleVal = headV1 & headA;
            OP_SLLI:  simpleVal = headV1 << headA[SHW-1:0];
            OP_SRLI:  simpleVal = headV1 >> headA[SHW-1:0];
            OP_SRAI:  simpleVal = $unsigned($signed(headV1) >>> headA[SHW-1:0]);
            OP_ADD:   simpleVal = headV1 + headV2;
            OP_SUB:   simpleVal = headV1 - headV2;
            OP_SLL:   simpleVal = headV1 << headV2[SHW-1:0];
            OP_SLT:   simpleVal = {{(XLEN-1){1'b0}}, $signed(headV1) < $signed(headV2)};
            OP_SLTU:  simpleVal = {{(XLEN-1){1'b0}}, headV1 < headV2};
            OP_XOR:   simpleVal = headV1 ^ headV2;
            OP_SRL:   simpleVal = headV1 >> headV2[SHW-1:0];
            OP_SRA:   simpleVal = $unsigned($signed(headV1) >>> headV2[SHW-1:0]);
            OP_OR:    simpleVal = headV1 | headV2;
            OP_AND:   simpleVal = headV1 & headV2;
            default:  simpleVal = '0;
        endcase
        if (brTaken) simpleRelPc = headPc + headA;
    end

    // One shift-add step: the multiplicand is pre-shifted each cycle, so the
    // low MUL_STEP multiplier bits always weight bit positions 0..MUL_STEP-1.
    always_comb begin
        mulPartial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mulMplier_q[j]) mulPartial = mulPartial + (mulMcand_q << j);
        end
        mulAccNext = mulAcc_q + mulPartial;
        mulProduct = mulNeg_q ? -mulAccNext : mulAccNext;
        mulResult  = mulHi_q ? mulProduct[2*XLEN-1:XLEN] : mulProduct[XLEN-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            codeMem[tailPtr_q] <= in_code;
            v1Mem[tailPtr_q]   <= in_v1;
            v2Mem[tailPtr_q]   <= in_v2;
            aMem[tailPtr_q]    <= in_a;
            pcMem[tailPtr_q]   <= in_pc;
            robMem[tailPtr_q]  <= in_rob_id;
        end
    end

    // Flush outranks the enable, so a frozen unit can still be cleared.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= S_IDLE;
            headPtr_q   <= '0;
            tailPtr_q   <= '0;
            count_q     <= '0;
            out_val     <= '0;
            out_rel_pc  <= '0;
            out_rob_id  <= '0;
            mulMcand_q  <= '0;
            mulMplier_q <= '0;
            mulAcc_q    <= '0;
            mulNeg_q    <= 1'b0;
            mulHi_q     <= 1'b0;
            mulCnt_q    <= '0;
            mulPc4_q    <= '0;
            mulRob_q    <= '0;
        end else if (flush_in) begin
            state_q   <= S_IDLE;
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            if (push) tailPtr_q <= tailPtr_q + PW'(1);
            if (pop)  headPtr_q <= headPtr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
            if (loadSimple) begin
                out_val    <= simpleVal;
                out_rel_pc <= simpleRelPc;
                out_rob_id <= headRob;
            end
            if (startMul) begin
                mulMcand_q  <= {{XLEN{1'b0}}, magA};
                mulMplier_q <= magB;
                mulAcc_q    <= '0;
                mulNeg_q    <= aNeg ^ bNeg;
                mulHi_q     <= (headCode != OP_MUL);
                mulCnt_q    <= '0;
                mulPc4_q    <= headPc + FOUR;
                mulRob_q    <= headRob;
            end
            if (mulStep) begin
                mulAcc_q    <= mulAccNext;
                mulMcand_q  <= mulMcand_q << MUL_STEP;
                mulMplier_q <= mulMplier_q >> MUL_STEP;
                mulCnt_q    <= mulCnt_q + CW'(1);
            end
            if (mulDone) begin
                out_val    <= mulResult;
                out_rel_pc <= mulPc4_q;
                out_rob_id <= mulRob_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed testbench for alu_pipe with default parameters
// (XLEN=32, ROBBW=4, DEPTH=4, MUL_STEP=4). Expected values are worked out
// by hand for each vector.
module tb_alu_pipe;

    localparam logic [5:0] OP_JALR  = 6'd4,  OP_BEQ   = 6'd5,  OP_BLT  = 6'd7;
    localparam logic [5:0] OP_ADDI  = 6'd11, OP_ADD   = 6'd20, OP_SUB  = 6'd21;
    localparam logic [5:0] OP_SLTU  = 6'd24, OP_XOR   = 6'd25, OP_SRA  = 6'd27;
    localparam logic [5:0] OP_LUI   = 6'd1,  OP_MUL   = 6'd30, OP_MULH = 6'd31;
    localparam logic [5:0] OP_MULHSU = 6'd32, OP_MULHU = 6'd33, OP_BAD = 6'd63;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_code = '0;
    logic [31:0] in_v1 = '0, in_v2 = '0, in_a = '0, in_pc = '0;
    logic [3:0]  in_rob_id = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_rob_id;
    logic [31:0] out_val, out_rel_pc;

    int vectors = 0;
    int miscompares = 0;
    int seen;

    alu_pipe dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .rdy_in    (rdy_in),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_v1     (in_v1),
        .in_v2     (in_v2),
        .in_a      (in_a),
        .in_pc     (in_pc),
        .in_rob_id (in_rob_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rob_id(out_rob_id),
        .out_val   (out_val),
        .out_rel_pc(out_rel_pc)
    );

    always #5 clk_in = ~clk_in;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Offer one instruction for exactly one rising edge.
    task automatic applyStimulus(input logic [5:0] code, input logic [31:0] v1, input logic [31:0] v2,
                                 input logic [31:0] a, input logic [31:0] pc, input logic [3:0] rob);
        in_code = code; in_v1 = v1; in_v2 = v2; in_a = a; in_pc = pc; in_rob_id = rob;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Simple op into an idle unit: result visible one edge after the push,
    // then consumed by a one-cycle grant.
    task automatic runSimple(input string tag, input logic [5:0] code, input logic [31:0] v1,
                             input logic [31:0] v2, input logic [31:0] a, input logic [31:0] pc,
                             input logic [3:0] rob, input logic [31:0] expVal, input logic [31:0] expRel);
        applyStimulus(code, v1, v2, a, pc, rob);
        checkOutput({tag, ".notYet"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, ".val"}, out_val, expVal);
        checkOutput({tag, ".relPc"}, out_rel_pc, expRel);
        checkOutput({tag, ".rob"}, {28'b0, out_rob_id}, {28'b0, rob});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, ".consumed"}, {31'b0, out_valid}, 32'd0);
    endtask

    // Multiply: result appears exactly 9 edges after the push edge.
    task automatic runMul(input string tag, input logic [5:0] code, input logic [31:0] v1,
                          input logic [31:0] v2, input logic [3:0] rob, input logic [31:0] expVal);
        applyStimulus(code, v1, v2, 32'd0, 32'h300, rob);
        repeat (8) tick();
        checkOutput({tag, ".early"}, {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, ".val"}, out_val, expVal);
        checkOutput({tag, ".relPc"}, out_rel_pc, 32'h304);
        checkOutput({tag, ".rob"}, {28'b0, out_rob_id}, {28'b0, rob});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state while reset is held.
        #2 rst_in = 1'b0;
        tick();
        tick();
        checkOutput("rst.valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst.val", out_val, 32'd0);
        checkOutput("rst.relPc", out_rel_pc, 32'd0);
        checkOutput("rst.rob", {28'b0, out_rob_id}, 32'd0);
        checkOutput("rst.inReady", {31'b0, in_ready}, 32'd1);
        rst_in = 1'b1;
        tick();

        // Single-cycle ops.
        runSimple("add",   OP_ADD,  32'd5, 32'd7, 32'd0, 32'h1000, 4'd3, 32'd12, 32'h1004);
        runSimple("sra",   OP_SRA,  32'h8000_0000, 32'h24, 32'd0, 32'h1010, 4'd5, 32'hF800_0000, 32'h1014);
        runSimple("blt",   OP_BLT,  32'hFFFF_FFFF, 32'd0, 32'h10, 32'h100, 4'd6, 32'd0, 32'h110);
        runSimple("jalr",  OP_JALR, 32'h203, 32'd0, 32'd0, 32'h40, 4'd7, 32'h44, 32'h202);
        runSimple("beqNT", OP_BEQ,  32'd1, 32'd2, 32'h20, 32'h200, 4'd8, 32'd0, 32'h204);
        runSimple("sltu",  OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h20, 4'd9, 32'd1, 32'h24);
        runSimple("sub",   OP_SUB,  32'd5, 32'd7, 32'd0, 32'h30, 4'd10, 32'hFFFF_FFFE, 32'h34);
        runSimple("lui",   OP_LUI,  32'd0, 32'd0, 32'h1234_5000, 32'h50, 4'd11, 32'h1234_5000, 32'h54);
        runSimple("bad",   OP_BAD,  32'd9, 32'd9, 32'd9, 32'h60, 4'd12, 32'd0, 32'h64);

        // Fill the FIFO behind an unconsumed result, then drain in order.
        applyStimulus(OP_ADD, 32'd1, 32'd1, 32'd0, 32'h400, 4'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OP_ADDI, 32'd100, 32'd0, 32'(i), 32'h500, 4'(4 + i));
            if (i == 2) checkOutput("fifo.readyAt3", {31'b0, in_ready}, 32'd1);
        end
        checkOutput("fifo.fullAt4", {31'b0, in_ready}, 32'd0);
        applyStimulus(OP_ADDI, 32'd999, 32'd0, 32'd0, 32'h500, 4'd15);
        checkOutput("fifo.stillFull", {31'b0, in_ready}, 32'd0);
        checkOutput("fifo.heldVal", out_val, 32'd2);
        checkOutput("fifo.heldRob", {28'b0, out_rob_id}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("fifo.valid%0d", i), {31'b0, out_valid}, 32'd1);
            checkOutput($sformatf("fifo.val%0d", i), out_val, 32'(100 + i));
            checkOutput($sformatf("fifo.rob%0d", i), {28'b0, out_rob_id}, 32'(4 + i));
            checkOutput($sformatf("fifo.relPc%0d", i), out_rel_pc, 32'h504);
        end
        tick();
        checkOutput("fifo.fifthDropped", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Multiplies.
        runMul("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'd0);
        runMul("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd3, 32'hFFFF_FFFE);
        runMul("mulhsu", OP_MULHSU, 32'hFFFF_FFFE, 32'd3, 4'd4, 32'hFFFF_FFFF);
        runMul("mul",    OP_MUL,    32'h0001_0000, 32'h0001_0000, 4'd5, 32'd0);
        runMul("mulNeg", OP_MUL,    32'd7, 32'hFFFF_FFFD, 4'd6, 32'hFFFF_FFEB);

        // Flush during the third multiply step with two entries queued;
        // a push offered in the flush cycle is dropped too.
        applyStimulus(OP_MUL, 32'd3, 32'd4, 32'd0, 32'h600, 4'd7);
        applyStimulus(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h604, 4'd8);
        applyStimulus(OP_ADD, 32'd3, 32'd4, 32'd0, 32'h608, 4'd9);
        tick();
        flush_in = 1'b1;
        applyStimulus(OP_ADD, 32'd5, 32'd6, 32'd0, 32'h60C, 4'd10);
        flush_in = 1'b0;
        checkOutput("flush.valid", {31'b0, out_valid}, 32'd0);
        checkOutput("flush.inReady", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("flush.noDelivery", 32'(seen), 32'd0);
        out_ready = 1'b0;
        runSimple("postFlush", OP_ADD, 32'd2, 32'd3, 32'd0, 32'h700, 4'd11, 32'd5, 32'h704);

        // Freeze mid-multiply for 5 cycles with the grant held high.
        out_ready = 1'b1;
        applyStimulus(OP_MUL, 32'd6, 32'd7, 32'd0, 32'h800, 4'd12);
        repeat (3) tick();
        rdy_in = 1'b0;
        repeat (5) tick();
        rdy_in = 1'b1;
        repeat (5) tick();
        checkOutput("freeze.notYet", {31'b0, out_valid}, 32'd0);
        tick();
        checkOutput("freeze.valid", {31'b0, out_valid}, 32'd1);
        checkOutput("freeze.val", out_val, 32'd42);
        checkOutput("freeze.rob", {28'b0, out_rob_id}, 32'd12);
        rdy_in = 1'b0;
        repeat (2) tick();
        checkOutput("freeze.noConsume", {31'b0, out_valid}, 32'd1);
        checkOutput("freeze.holdVal", out_val, 32'd42);
        rdy_in = 1'b1;
        tick();
        checkOutput("freeze.consumed", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a multiply.
        applyStimulus(OP_MUL, 32'd3, 32'd5, 32'd0, 32'h900, 4'd13);
        repeat (3) tick();
        rst_in = 1'b0;
        #1;
        checkOutput("midRst.valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midRst.val", out_val, 32'd0);
        checkOutput("midRst.relPc", out_rel_pc, 32'd0);
        checkOutput("midRst.rob", {28'b0, out_rob_id}, 32'd0);
        checkOutput("midRst.inReady", {31'b0, in_ready}, 32'd1);
        tick();
        rst_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("midRst.aborted", 32'(seen), 32'd0);
        runSimple("postRst", OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'hA00, 4'd14, 32'h0000_FF00, 32'hA04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
